// File: rtl/comp_result_window.sv
// Windowed accumulator for comparator verdicts: counts eq/gt/lt over WINDOW
// accepted samples, then presents the counts and a majority code on a valid/ready port.
// Optional macro COMP_STREAK_EN enables the consecutive-equal streak detector.
module comp_result_window #(
  parameter int CNT_W      = 8,
  parameter int WINDOW     = 16,
  parameter int STREAK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_eq,
  input  logic             in_gt,
  input  logic             in_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_eq_cnt,
  output logic [CNT_W-1:0] out_gt_cnt,
  output logic [CNT_W-1:0] out_lt_cnt,
  output logic [1:0]       out_major,
  output logic             err_onehot,
  input  logic             err_clr,
  output logic             streak
);

  typedef enum logic {ACC = 1'b0, REPORT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] eq_cnt, gt_cnt, lt_cnt;
  logic             accept, take, onehot;

  assign accept = in_ready & in_valid;
  assign take   = out_valid & out_ready;
  // exactly one flag: odd parity rules out two, the AND term rules out three
  assign onehot = (in_eq ^ in_gt ^ in_lt) & ~(in_eq & in_gt & in_lt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && idx == LAST_IDX) state_nxt = REPORT;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      eq_cnt <= '0;
      gt_cnt <= '0;
      lt_cnt <= '0;
    end else if (take) begin
      idx    <= '0;
      eq_cnt <= '0;
      gt_cnt <= '0;
      lt_cnt <= '0;
    end else if (accept) begin
      idx <= idx + CNT_W'(1);
      if (onehot) begin
        if (in_eq) eq_cnt <= eq_cnt + CNT_W'(1);
        if (in_gt) gt_cnt <= gt_cnt + CNT_W'(1);
        if (in_lt) lt_cnt <= lt_cnt + CNT_W'(1);
      end
    end
  end

  assign out_eq_cnt = eq_cnt;
  assign out_gt_cnt = gt_cnt;
  assign out_lt_cnt = lt_cnt;

  always_comb begin
    out_major = 2'b11;
    if      (eq_cnt > gt_cnt && eq_cnt > lt_cnt) out_major = 2'b00;
    else if (gt_cnt > eq_cnt && gt_cnt > lt_cnt) out_major = 2'b01;
    else if (lt_cnt > eq_cnt && lt_cnt > gt_cnt) out_major = 2'b10;
  end

  // set has priority over clear; window rollover never touches it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_onehot <= 1'b0;
    else if (accept && !onehot) err_onehot <= 1'b1;
    else if (err_clr)          err_onehot <= 1'b0;
  end

`ifdef COMP_STREAK_EN
  localparam logic [CNT_W-1:0] STREAK_THR = CNT_W'(STREAK_LEN);

  logic [CNT_W-1:0] run, run_nxt;
  logic             eq_only;

  assign eq_only = in_eq & ~in_gt & ~in_lt;

  always_comb begin
    run_nxt = '0;
    if (eq_only) run_nxt = (run >= STREAK_THR) ? run : run + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= '0;
      streak <= 1'b0;
    end else if (accept) begin
      run    <= run_nxt;
      streak <= (run_nxt >= STREAK_THR);
    end
  end
`else
  assign streak = 1'b0;
`endif

endmodule

// File: tb/tb_comp_result_window.sv
// Scoreboard bench for comp_result_window: a window-level reference model
// queues expected summaries, a negedge monitor checks handshake outputs.
module tb_comp_result_window;
  localparam int CNT_W      = 8;
  localparam int WINDOW     = 4;
  localparam int STREAK_LEN = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_eq = 1'b0, in_gt = 1'b0, in_lt = 1'b0;
  logic out_ready = 1'b0, err_clr = 1'b0;
  logic in_ready, out_valid, err_onehot, streak;
  logic [CNT_W-1:0] out_eq_cnt, out_gt_cnt, out_lt_cnt;
  logic [1:0] out_major;

  comp_result_window #(.CNT_W(CNT_W), .WINDOW(WINDOW), .STREAK_LEN(STREAK_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_eq(in_eq), .in_gt(in_gt), .in_lt(in_lt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_eq_cnt(out_eq_cnt), .out_gt_cnt(out_gt_cnt), .out_lt_cnt(out_lt_cnt),
    .out_major(out_major), .err_onehot(err_onehot), .err_clr(err_clr),
    .streak(streak)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         eq;
    int         gt;
    int         lt;
    logic [1:0] major;
  } sum_t;

  sum_t sb_q[$];
  int   win[$];   // verdict codes of the open window: 0 eq, 1 gt, 2 lt, 3 bad
  bit   m_rep, m_err;
  int   m_run;
  int   n_tests = 0, n_fail = 0;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic sum_t summarize(int w[$]);
    sum_t s;
    int   mx, n_at;
    s.eq = 0; s.gt = 0; s.lt = 0;
    foreach (w[i]) begin
      if (w[i] == 0) s.eq++;
      if (w[i] == 1) s.gt++;
      if (w[i] == 2) s.lt++;
    end
    mx = s.eq;
    if (s.gt > mx) mx = s.gt;
    if (s.lt > mx) mx = s.lt;
    n_at = (s.eq == mx) + (s.gt == mx) + (s.lt == mx);
    if (n_at > 1)       s.major = 2'b11;
    else if (s.eq == mx) s.major = 2'b00;
    else if (s.gt == mx) s.major = 2'b01;
    else                 s.major = 2'b10;
    return s;
  endfunction

  // reference model: windows as lists of verdicts, streak as an unbounded run length
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win.delete();
      m_rep = 1'b0;
      m_err = 1'b0;
      m_run = 0;
    end else begin
      int  code, nset;
      bit  acc;
      acc  = !m_rep && in_valid;
      nset = int'(in_eq) + int'(in_gt) + int'(in_lt);
      code = (nset != 1) ? 3 : (in_eq ? 0 : (in_gt ? 1 : 2));
      if (acc && code == 3) m_err = 1'b1;
      else if (err_clr)     m_err = 1'b0;
      if (acc) begin
        win.push_back(code);
        m_run = (code == 0) ? m_run + 1 : 0;
        if (win.size() == WINDOW) begin
          sb_q.push_back(summarize(win));
          win.delete();
          m_rep = 1'b1;
        end
      end else if (m_rep && out_ready) begin
        m_rep = 1'b0;
      end
    end
  end

  function automatic bit exp_streak();
`ifdef COMP_STREAK_EN
    return m_run >= STREAK_LEN;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(!m_rep));
    chk("out_valid", int'(out_valid), int'(m_rep));
    chk("err_onehot", int'(err_onehot), int'(m_err));
    chk("streak", int'(streak), int'(exp_streak()));
    if (out_valid) begin
      if (sb_q.size() == 0) chk("unexpected_summary", 1, 0);
      else begin
        chk("eq_cnt", int'(out_eq_cnt), sb_q[0].eq);
        chk("gt_cnt", int'(out_gt_cnt), sb_q[0].gt);
        chk("lt_cnt", int'(out_lt_cnt), sb_q[0].lt);
        chk("major", int'(out_major), int'(sb_q[0].major));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(bit e, bit g, bit l);
    in_valid = 1'b1; in_eq = e; in_gt = g; in_lt = l;
    step();
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_eq"}, int'(out_eq_cnt), 0);
    chk({tag, "_gt"}, int'(out_gt_cnt), 0);
    chk({tag, "_lt"}, int'(out_lt_cnt), 0);
    chk({tag, "_major"}, int'(out_major), 3);
    chk({tag, "_err"}, int'(err_onehot), 0);
    chk({tag, "_streak"}, int'(streak), 0);
  endtask

  initial begin
    int r, k;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    // clean window, consumer always ready
    out_ready = 1'b1;
    send(1,0,0); send(0,1,0); send(0,1,0); send(0,0,1);
    idle(2);

    // backpressure with in_valid pulses during the stall
    out_ready = 1'b0;
    repeat (4) send(0,0,1);
    repeat (5) send($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1));
    out_ready = 1'b1;
    idle(2);

    // tie plus one-hot errors, then clear colliding with a new error
    send(1,0,0); send(0,1,0); send(1,1,0); send(0,0,0);
    idle(1);
    err_clr = 1'b1;
    send(1,1,1);
    err_clr = 1'b0;
    idle(1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;

    // reset mid-window: partial window is discarded
    send(0,1,0); send(0,0,1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0,0,1); send(1,0,0); send(0,0,1); send(0,1,0);
    idle(2);

    // streak across a window boundary
    send(0,1,0);
    repeat (3) send(1,0,0);
    idle(1);
    send(1,0,0); send(1,0,0); send(0,1,0);
    idle(1);
    send(0,0,1);
    idle(1);

    // idle gaps between samples
    repeat (4) begin
      send(0,1,0);
      idle(2);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 2);
      in_valid  = $urandom_range(0, 2) != 0;
      if (r < 8) begin
        in_eq = (k == 0); in_gt = (k == 1); in_lt = (k == 2);
      end else begin
        in_eq = $urandom_range(0,1); in_gt = $urandom_range(0,1); in_lt = $urandom_range(0,1);
      end
      out_ready = $urandom_range(0, 2) != 0;
      err_clr   = $urandom_range(0, 7) == 0;
      step();
    end

    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
